// File: rtl/branch_predictor.sv
// Tournament branch predictor: bimodal (PHT1) and gshare (PHT2) tables of 2-bit
// counters, a per-PC chooser, a global history register and resolution statistics.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst,
  input  logic [31:0]         pc,
  output logic                predict1,
  output logic                predict2,
  output logic                pprediction,
  output logic [IDX_BITS-1:0] ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [IDX_BITS-1:0] upd_ghr,
  input  logic                PCsel,
  input  logic                taken1,
  input  logic                taken2,
  input  logic                true,
  output logic [15:0]         branch_count,
  output logic [15:0]         mispredict_count
);

  localparam int         ENTRIES   = 1 << IDX_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [1:0] ctr_t;

  ctr_t pht1    [ENTRIES];
  ctr_t pht2    [ENTRIES];
  ctr_t chooser [ENTRIES];

  logic [IDX_BITS-1:0] i1, i2, u1, u2;
  logic                is_branch;

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign i1        = pc[IDX_BITS+1:2];
  assign i2        = i1 ^ ghr;
  assign u1        = upd_pc[IDX_BITS+1:2];
  assign u2        = u1 ^ upd_ghr;
  assign is_branch = (inst[6:0] == OP_BRANCH);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    predict1    = 1'b0;
    predict2    = 1'b0;
    pprediction = 1'b0;
    if (is_branch) begin
      predict1    = pht1[i1][1];
      predict2    = pht2[i2][1];
      pprediction = chooser[i1][1] ? predict2 : predict1;
    end
  end

  // Reads above see the pre-edge table contents, so a same-cycle update is visible next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tables must come out of reset weakly not-taken, so every entry is
      // written here rather than left uninitialised like a plain RAM.
      for (int k = 0; k < ENTRIES; k++) begin
        pht1[k]    <= 2'b01;
        pht2[k]    <= 2'b01;
        chooser[k] <= 2'b01;
      end
      ghr              <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      pht1[u1] <= sat_step(pht1[u1], PCsel);
      pht2[u2] <= sat_step(pht2[u2], PCsel);
      if (taken1 != taken2) begin
        chooser[u1] <= sat_step(chooser[u1], taken2);
      end
      ghr          <= {ghr[IDX_BITS-2:0], PCsel};
      branch_count <= sat_inc16(branch_count);
      if (!true) begin
        mispredict_count <= sat_inc16(mispredict_count);
      end
    end
  end

  // Instruction and PC bits outside the opcode and index fields do not affect prediction.
  logic unused_ok;
  assign unused_ok = &{1'b0, inst[31:7], pc[31:IDX_BITS+2], pc[1:0],
                       upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table followed by randomized traffic
// compared against an array-based reference model.
module tb_branch_predictor;

  localparam int IB = 4;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst, pc, upd_pc;
  logic          predict1, predict2, pprediction;
  logic [IB-1:0] ghr, upd_ghr;
  logic          upd_valid, PCsel, taken1, taken2, tru;
  logic [15:0]   branch_count, mispredict_count;

  branch_predictor #(.IDX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc),
    .predict1(predict1), .predict2(predict2), .pprediction(pprediction), .ghr(ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .PCsel(PCsel),
    .taken1(taken1), .taken2(taken2), .true(tru),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [3:0]  ughr;
    logic        pcs, t1, t2, tr;
    logic        e1, e2, ep;
    logic [3:0]  eghr;
    int          ebc, emc;
  } vec_t;

  vec_t vecs[16];

  // Reference model: counters kept as plain integers clamped to 0..3.
  int m_pht1[N], m_pht2[N], m_ch[N];
  int m_ghr, m_bc, m_mc;

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_step();
    int u1, u2;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_pht1[k] = 1; m_pht2[k] = 1; m_ch[k] = 1;
      end
      m_ghr = 0; m_bc = 0; m_mc = 0;
    end else if (upd_valid) begin
      u1 = (upd_pc / 4) % N;
      u2 = u1 ^ int'(upd_ghr);
      m_pht1[u1] = clamp(m_pht1[u1] + (PCsel ? 1 : -1), 3);
      m_pht2[u2] = clamp(m_pht2[u2] + (PCsel ? 1 : -1), 3);
      if (taken1 != taken2) m_ch[u1] = clamp(m_ch[u1] + (taken2 ? 1 : -1), 3);
      m_ghr = (m_ghr * 2 + int'(PCsel)) % N;
      m_bc  = clamp(m_bc + 1, 65535);
      if (!tru) m_mc = clamp(m_mc + 1, 65535);
    end
  endtask

  task automatic model_check();
    int  i1, i2;
    bit  br, p1, p2, pp;
    br = ((inst % 128) == 32'h63);
    i1 = (pc / 4) % N;
    i2 = i1 ^ m_ghr;
    p1 = br && (m_pht1[i1] >= 2);
    p2 = br && (m_pht2[i2] >= 2);
    pp = br && ((m_ch[i1] >= 2) ? p2 : p1);
    check("rnd_predict1", predict1, p1);
    check("rnd_predict2", predict2, p2);
    check("rnd_pprediction", pprediction, pp);
    check("rnd_ghr", ghr, m_ghr);
    check("rnd_branch_count", branch_count, m_bc);
    check("rnd_mispredict_count", mispredict_count, m_mc);
  endtask

  initial begin
    rst = 1'b1; inst = 32'h63; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0;
    PCsel = 1'b0; taken1 = 1'b0; taken2 = 1'b0; tru = 1'b0;

    //            rst br pc      uv upc     ughr pcs t1 t2 tr   e1 e2 ep ghr  bc  mc
    vecs[0]  = '{0, 1, 32'h40, 0, 32'h00, 0,   0,  0, 0, 0,   0, 0, 0, 4'h0, 0,  0};
    vecs[1]  = '{0, 1, 32'h40, 1, 32'h40, 0,   1,  0, 0, 0,   0, 0, 0, 4'h0, 0,  0};
    vecs[2]  = '{0, 1, 32'h40, 1, 32'h40, 0,   1,  0, 0, 0,   1, 0, 1, 4'h1, 1,  1};
    vecs[3]  = '{0, 1, 32'h40, 0, 32'h40, 0,   1,  0, 1, 0,   1, 0, 1, 4'h3, 2,  2};
    vecs[4]  = '{0, 0, 32'h40, 1, 32'h40, 0,   1,  1, 1, 1,   0, 0, 0, 4'h3, 2,  2};
    vecs[5]  = '{0, 0, 32'h40, 1, 32'h40, 0,   1,  1, 1, 1,   0, 0, 0, 4'h7, 3,  2};
    vecs[6]  = '{0, 0, 32'h40, 1, 32'h40, 0,   1,  1, 1, 1,   0, 0, 0, 4'hF, 4,  2};
    vecs[7]  = '{0, 0, 32'h40, 1, 32'h40, 0,   0,  0, 0, 0,   0, 0, 0, 4'hF, 5,  2};
    vecs[8]  = '{0, 1, 32'h40, 0, 32'h00, 0,   0,  0, 0, 0,   1, 0, 1, 4'hE, 6,  3};
    vecs[9]  = '{0, 1, 32'h44, 1, 32'h44, 0,   1,  0, 1, 1,   0, 0, 0, 4'hE, 6,  3};
    vecs[10] = '{0, 1, 32'h44, 1, 32'h44, 0,   1,  0, 1, 1,   1, 0, 0, 4'hD, 7,  3};
    vecs[11] = '{0, 1, 32'h44, 1, 32'h44, 0,   1,  1, 1, 1,   1, 0, 0, 4'hB, 8,  3};
    vecs[12] = '{0, 1, 32'h44, 1, 32'h44, 0,   1,  1, 1, 1,   1, 0, 0, 4'h7, 9,  3};
    vecs[13] = '{0, 1, 32'h40, 0, 32'h00, 0,   0,  0, 0, 0,   1, 0, 1, 4'hF, 10, 3};
    vecs[14] = '{1, 1, 32'h44, 1, 32'h40, 0,   1,  0, 1, 0,   1, 0, 0, 4'hF, 10, 3};
    vecs[15] = '{0, 1, 32'h40, 0, 32'h00, 0,   0,  0, 0, 0,   0, 0, 0, 4'h0, 0,  0};

    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      rst = vecs[v].rst; inst = vecs[v].br ? 32'h0000_0063 : 32'h0000_0033;
      pc = vecs[v].pc; upd_valid = vecs[v].uv; upd_pc = vecs[v].upc;
      upd_ghr = vecs[v].ughr; PCsel = vecs[v].pcs; taken1 = vecs[v].t1;
      taken2 = vecs[v].t2; tru = vecs[v].tr;
      #1;
      check($sformatf("v%0d_predict1", v), predict1, vecs[v].e1);
      check($sformatf("v%0d_predict2", v), predict2, vecs[v].e2);
      check($sformatf("v%0d_pprediction", v), pprediction, vecs[v].ep);
      check($sformatf("v%0d_ghr", v), ghr, vecs[v].eghr);
      check($sformatf("v%0d_branch_count", v), branch_count, vecs[v].ebc);
      check($sformatf("v%0d_mispredict_count", v), mispredict_count, vecs[v].emc);
      @(negedge clk);
    end

    // Post-reset sweep: every entry must read weakly not-taken.
    rst = 1'b0; upd_valid = 1'b0; inst = 32'h63;
    for (int k = 0; k < N; k++) begin
      pc = k * 4;
      #1;
      check($sformatf("sweep%0d_p1", k), predict1, 1'b0);
      check($sformatf("sweep%0d_p2", k), predict2, 1'b0);
      @(negedge clk);
    end

    // Randomized traffic against the model, starting from a fresh reset.
    rst = 1'b1;
    model_step();
    @(negedge clk);
    for (int c = 0; c < 800; c++) begin
      logic [31:0] r;
      r = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      inst = ($urandom_range(0, 3) != 0) ? {r[31:7], 7'b1100011} : r;
      pc = $urandom_range(0, 255);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = $urandom_range(0, 255);
      upd_ghr = IB'($urandom);
      PCsel = ($urandom_range(0, 2) != 0);
      taken1 = 1'($urandom); taken2 = 1'($urandom); tru = 1'($urandom);
      #1;
      model_check();
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 4, which sets the table index width (2^IDX_BITS entries per table) and the GHR width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port inst, input, 32 bits: the instruction being fetched (lookup side).
REQ-005 The block SHALL have port pc, input, 32 bits: the fetch PC of inst.
REQ-006 The block SHALL have port predict1, output, 1 bit: the local (bimodal) predictor's taken prediction.
REQ-007 The block SHALL have port predict2, output, 1 bit: the global (gshare) predictor's taken prediction.
REQ-008 The block SHALL have port pprediction, output, 1 bit: the final prediction picked by the chooser.
REQ-009 The block SHALL have port ghr, output, IDX_BITS bits: the current global history, which fetch carries with the branch.
REQ-010 The block SHALL have port upd_valid, input, 1 bit: a branch resolved this cycle.
REQ-011 The block SHALL have port upd_pc, input, 32 bits: the PC of the resolved branch.
REQ-012 The block SHALL have port upd_ghr, input, IDX_BITS bits: the GHR snapshot taken when the resolved branch was predicted.
REQ-013 The block SHALL have port PCsel, input, 1 bit: the actual outcome (1 = taken).
REQ-014 The block SHALL have port taken1, input, 1 bit: predict1 was correct.
REQ-015 The block SHALL have port taken2, input, 1 bit: predict2 was correct.
REQ-016 The block SHALL have port true, input, 1 bit: pprediction was correct.
REQ-017 The block SHALL have port branch_count, output, 16 bits: the number of resolved branches.
REQ-018 The block SHALL have port mispredict_count, output, 16 bits: the number of final mispredictions.

Function
REQ-019 The block SHALL hold three tables of 2^IDX_BITS 2-bit saturating counters: PHT1, PHT2 and CHOOSER.
REQ-020 Lookup indexes SHALL be: i1 = pc[IDX_BITS+1:2]; i2 = pc[IDX_BITS+1:2] XOR ghr.
REQ-021 Lookup SHALL be combinational within the cycle: predict1 = PHT1[i1][1]; predict2 = PHT2[i2][1]; pprediction = CHOOSER[i1][1] ? predict2 : predict1.
REQ-022 When inst[6:0] != 7'b1100011, predict1, predict2 and pprediction SHALL all be 0.
REQ-023 Lookup SHALL never modify any state.
REQ-024 Update indexes SHALL be: u1 = upd_pc[IDX_BITS+1:2]; u2 = upd_pc[IDX_BITS+1:2] XOR upd_ghr.
REQ-025 On a clock edge with upd_valid=1, PHT1[u1] and PHT2[u2] SHALL increment if PCsel=1 and decrement if PCsel=0, saturating at 11 and 00.
REQ-026 On the same edge, when taken1 != taken2, CHOOSER[u1] SHALL increment if taken2=1 and decrement if taken1=1, saturating; when taken1 == taken2 it SHALL be unchanged.
REQ-027 On the same edge, ghr SHALL become {ghr[IDX_BITS-2:0], PCsel}.
REQ-028 On the same edge, branch_count SHALL increment, saturating at 16'hFFFF.
REQ-029 On the same edge, mispredict_count SHALL increment when true=0, saturating at 16'hFFFF.
REQ-030 When a lookup and an update hit the same entry in the same cycle, the lookup SHALL return the pre-update value; the new value SHALL be visible from the next cycle.
REQ-031 When u1 == u2, PHT1 and PHT2 SHALL each update independently.
REQ-032 When upd_valid=0, taken1, taken2, true and PCsel SHALL be ignored and all state SHALL hold.
REQ-033 The update path SHALL have 1-cycle latency, and there SHALL be no stall or backpressure; one update per cycle SHALL be sustainable.

Reset
REQ-034 When rst=1 at a clock edge, every PHT1, PHT2 and CHOOSER entry SHALL be set to 01 and ghr, branch_count and mispredict_count SHALL be set to 0.
REQ-035 rst SHALL take priority over a simultaneous upd_valid, and that update SHALL be discarded.
REQ-036 After reset, any branch lookup SHALL return predict1=predict2=pprediction=0.

Verification
REQ-037 Reset, then inst=beq (opcode 1100011), pc=0x40 -> predict1=0, predict2=0, pprediction=0, ghr=0.
REQ-038 Two updates with upd_pc=0x40, upd_ghr=0, PCsel=1, taken1=0, taken2=0, true=0 -> PHT1[0]=11, ghr=0011, mispredict_count=2, branch_count=2; a lookup at pc=0x40 with ghr=0011 -> predict1=1.
REQ-039 Saturation: three more taken updates at upd_pc=0x40 -> PHT1[0] stays 11; one not-taken update -> PHT1[0]=10 and predict1 is still 1.
REQ-040 Chooser: two updates at upd_pc=0x44 with taken1=0, taken2=1 -> CHOOSER[1]=11, and pprediction at pc=0x44 equals predict2; two updates with taken1=1, taken2=1 -> CHOOSER[1] is unchanged.
REQ-041 Non-branch inst (opcode 0110011) at any pc -> all predictions are 0 and no state changes.
REQ-042 Reset mid-run: rst=1 together with upd_valid=1 after ten updates -> all counters are 0, all table entries are 01, and the discarded update leaves no trace.
